// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: shared 640x480@60 video timing constants for timing, overlay and menu placement.
package vga_timing_gen_pkg;
  localparam int CNT_W = 10;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam logic VGA_SYNC_POL = 1'b0;
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel/line counters with registered, mutually aligned sync, blanking and frame outputs.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter logic SYNC_POL = VGA_SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             newline,
  output logic             newframe,
  output logic [7:0]       frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_DE = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_DE = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d, x_q, y_q;
  logic de_q, de_d, hs_q, hs_d, vs_q, vs_d, nl_q, nl_d, nf_q, nf_d;
  logic [7:0] frame_q;
  // Decode from the next counts so every registered output lands on the same pixel as x/y.
  always_comb begin
    h_d = h_q == H_LAST ? '0 : h_q + CNT_W'(1);
    v_d = h_q != H_LAST ? v_q : v_q == V_LAST ? '0 : v_q + CNT_W'(1);
    de_d = h_d < H_DE && v_d < V_DE;
    hs_d = h_d >= HS_BEG && h_d <= HS_END ? SYNC_POL : ~SYNC_POL;
    vs_d = v_d >= VS_BEG && v_d <= VS_END ? SYNC_POL : ~SYNC_POL;
    nl_d = h_d == '0;
    nf_d = nl_d && v_d == '0;
  end
  // Counters preset to the last pixel so the first enable after reset restarts at (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q <= H_LAST;
      v_q <= V_LAST;
      x_q <= '0;
      y_q <= '0;
      de_q <= 1'b0;
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
      nl_q <= 1'b0;
      nf_q <= 1'b0;
      frame_q <= '0;
    end else if (pix_en) begin
      h_q <= h_d;
      v_q <= v_d;
      x_q <= h_d;
      y_q <= v_d;
      de_q <= de_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      nl_q <= nl_d;
      nf_q <= nf_d;
      frame_q <= nf_d ? frame_q + 8'd1 : frame_q;
    end
  end
  assign x = x_q;
  assign y = y_q;
  assign de = de_q;
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign newline = nl_q;
  assign newframe = nf_q;
  assign frame_cnt = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a full-size 640x480 instance and a tiny 16x10 instance with SYNC_POL=1.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, en_a = 1'b0, en_b = 1'b0;
  logic [9:0] xa, ya, xb, yb;
  logic dea, hsa, vsa, nla, nfa, deb, hsb, vsb, nlb, nfb;
  logic [7:0] fca, fcb;
  int checks = 0;
  int errors = 0;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst_a), .pix_en(en_a), .x(xa), .y(ya), .de(dea), .hsync(hsa),
    .vsync(vsa), .newline(nla), .newframe(nfa), .frame_cnt(fca)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) u_b (
    .clk(clk), .rst(rst_b), .pix_en(en_b), .x(xb), .y(yb), .de(deb), .hsync(hsb),
    .vsync(vsb), .newline(nlb), .newframe(nfb), .frame_cnt(fcb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int de_n, hs_n, hs_min, hs_max, nl_n, mx, my, vs_n, vs_min, vs_max, nf_n, last_nf;
    #1 rst_a = 1'b0;
    rst_b = 1'b0;
    step();
    step();
    chk("rst_a_x", xa, 0);
    chk("rst_a_y", ya, 0);
    chk("rst_a_de", dea, 0);
    chk("rst_a_hs", hsa, 1);
    chk("rst_a_vs", vsa, 1);
    chk("rst_a_nl", nla, 0);
    chk("rst_a_nf", nfa, 0);
    chk("rst_a_fc", fca, 0);
    chk("rst_b_hs", hsb, 0);
    chk("rst_b_vs", vsb, 0);
    rst_a = 1'b1;
    en_a = 1'b1;
    de_n = 0; hs_n = 0; nl_n = 0; hs_min = 9999; hs_max = -1;
    for (int k = 1; k <= 801; k++) begin
      step();
      if (k == 1) begin
        chk("first_x", xa, 0);
        chk("first_y", ya, 0);
        chk("first_de", dea, 1);
        chk("first_nl", nla, 1);
        chk("first_nf", nfa, 1);
        chk("first_fc", fca, 1);
      end
      if (k == 2) begin
        chk("second_x", xa, 1);
        chk("second_nl", nla, 0);
        chk("second_nf", nfa, 0);
      end
      if (k <= 800) begin
        de_n += int'(dea);
        nl_n += int'(nla);
        if (!hsa) begin
          hs_n++;
          if (int'(xa) < hs_min) hs_min = int'(xa);
          if (int'(xa) > hs_max) hs_max = int'(xa);
        end
      end
      if (k == 801) begin
        chk("line2_x", xa, 0);
        chk("line2_y", ya, 1);
        chk("line2_nl", nla, 1);
      end
    end
    chk("line_de_cnt", de_n, 640);
    chk("line_hs_cnt", hs_n, 96);
    chk("line_hs_min", hs_min, 656);
    chk("line_hs_max", hs_max, 751);
    chk("line_nl_cnt", nl_n, 1);
    mx = 0; my = 1; nl_n = 0;
    for (int i = 0; i < 1602; i++) begin
      en_a = (i % 2 == 0);
      step();
      if (en_a) begin
        mx = (mx == 799) ? 0 : mx + 1;
        if (mx == 0) my++;
      end
      nl_n += int'(nla);
      chk("half_x", xa, mx);
      chk("half_y", ya, my);
      chk("half_de", dea, mx < 640 ? 1 : 0);
      chk("half_hs", hsa, (mx >= 656 && mx <= 751) ? 0 : 1);
    end
    chk("half_nl_cycles", nl_n, 2);
    en_a = 1'b0;

    rst_b = 1'b1;
    en_b = 1'b1;
    vs_n = 0; vs_min = 9999; vs_max = -1; nf_n = 0; last_nf = 0;
    for (int k = 1; k <= 321; k++) begin
      step();
      if (vsb) begin
        vs_n++;
        if (int'(yb) < vs_min) vs_min = int'(yb);
        if (int'(yb) > vs_max) vs_max = int'(yb);
      end
      if (nfb) begin
        nf_n++;
        if (last_nf != 0) chk("nf_gap", k - last_nf, 160);
        last_nf = k;
        chk("nf_x", xb, 0);
        chk("nf_y", yb, 0);
      end
    end
    chk("frames_fc", fcb, 3);
    chk("frames_nf_cnt", nf_n, 3);
    chk("frames_vs_cnt", vs_n, 64);
    chk("frames_vs_min", vs_min, 7);
    chk("frames_vs_max", vs_max, 8);
    repeat (252 * 160) step();
    chk("pre_wrap_fc", fcb, 255);
    chk("pre_wrap_nf", nfb, 1);
    repeat (159) step();
    chk("last_px_fc", fcb, 255);
    chk("last_px_nf", nfb, 0);
    chk("last_px_x", xb, 15);
    chk("last_px_y", yb, 9);
    step();
    chk("wrap_fc", fcb, 0);
    chk("wrap_nf", nfb, 1);
    repeat (53) step();
    chk("mid_x", xb, 5);
    chk("mid_y", yb, 3);
    chk("mid_de", deb, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("async_x", xb, 0);
    chk("async_y", yb, 0);
    chk("async_de", deb, 0);
    chk("async_fc", fcb, 0);
    chk("async_hs", hsb, 0);
    chk("async_vs", vsb, 0);
    @(negedge clk);
    repeat (3) step();
    chk("hold_rst_x", xb, 0);
    chk("hold_rst_nf", nfb, 0);
    rst_b = 1'b1;
    step();
    chk("restart_x", xb, 0);
    chk("restart_y", yb, 0);
    chk("restart_de", deb, 1);
    chk("restart_nl", nlb, 1);
    chk("restart_nf", nfb, 1);
    chk("restart_fc", fcb, 1);
    step();
    chk("restart_x1", xb, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, asserted level of hsync/vsync
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- clk, input, 1, single system clock; all logic on rising edge
- rst, input, 1, asynchronous active-low reset
- pix_en, input, 1, pixel-rate enable; counters advance only when high
- x, output, 10, current horizontal position, 0..H_TOTAL-1
- y, output, 10, current vertical position, 0..V_TOTAL-1
- de, output, 1, high when x<H_ACTIVE and y<V_ACTIVE
- hsync, output, 1, horizontal sync at SYNC_POL level
- vsync, output, 1, vertical sync at SYNC_POL level
- newline, output, 1, high while x==0
- newframe, output, 1, high while x==0 and y==0
- frame_cnt, output, 8, frame counter for blink/animation use

Function
REQ-003 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL SHALL equal the vertical sum (525). Both SHALL be ≤1024.
REQ-004 On a clk edge with pix_en=1, h_cnt SHALL increment and wrap from H_TOTAL-1 to 0.
REQ-005 When h_cnt wraps, v_cnt SHALL increment and wrap from V_TOTAL-1 to 0; v_cnt SHALL NOT change at any other time.
REQ-006 With pix_en=0, all counters and outputs SHALL hold their values.
REQ-007 All outputs SHALL be registered. They SHALL update on the same edge as the counters and be mutually aligned: x, y, de, hsync, vsync, newline and newframe all describe the same pixel.
REQ-008 hsync SHALL equal SYNC_POL for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751), and ~SYNC_POL otherwise.
REQ-009 vsync SHALL equal SYNC_POL for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), and ~SYNC_POL otherwise, independent of x.
REQ-010 newline SHALL be high for exactly one pixel period per line, the period with x==0. It is used downstream as an edge source, so it SHALL be glitch-free (driven directly from a flop).
REQ-011 newframe SHALL be high for exactly one pixel period per frame, at (0,0).
REQ-012 frame_cnt SHALL increment by 1 on the edge entering (0,0) and wrap 255→0.
REQ-013 x and y SHALL report the raw counters, including blanking positions. They SHALL NOT be clamped.

Reset
REQ-014 While rst=0, the outputs SHALL be:
- x=0, y=0, de=0, newline=0, newframe=0, frame_cnt=0
- hsync=~SYNC_POL, vsync=~SYNC_POL
REQ-015 While rst=0, the internal counters SHALL be preset to h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
REQ-016 The first pix_en edge after reset release SHALL produce x=0, y=0, de=1, newline=1, newframe=1 and frame_cnt=1.
REQ-017 Reset asserted mid-frame SHALL take effect immediately (asynchronous). No partial line or frame SHALL be emitted after release other than the restart per REQ-016.

Structure
REQ-018 The timing constants and the derived H_TOTAL/V_TOTAL SHALL live in the shared video parameter package/header, which is also used by the text-overlay stage and the menu window placement.
REQ-019 The block SHALL be a single module with no sub-module. The horizontal and vertical counters SHALL be inline, and output decode SHALL be computed from the next-count values so the registered outputs stay aligned.

Verification
REQ-020 Reset, then pix_en=1 continuously. Required response:
- first enabled edge: x=0, y=0, de=1, newline=1, newframe=1, frame_cnt=1
- next edge: x=1, newline=0, newframe=0
REQ-021 Run one full line. Required response:
- de high for exactly 640 enables
- hsync low (SYNC_POL=0) for exactly x=656..751
- newline high once, then again at enable 801 with y=1
REQ-022 Run two full frames. Required response:
- vsync low for exactly y=490..491 (1600 enables)
- newframe pulses exactly 420000 enables apart
- frame_cnt reaches 3
REQ-023 Drive pix_en as a 1-of-2 pattern. Required response:
- every output holds on pix_en=0 cycles
- the newline pulse lasts exactly 2 clk cycles
REQ-024 Assert rst at x=300, y=200 for 3 cycles, then release. Required response:
- outputs go to reset values immediately
- the next enable gives (0,0) with newframe=1 and frame_cnt=1
REQ-025 Set frame_cnt near wrap by running 256 frames (or force it to 255). Required response: the next newframe sets frame_cnt=0.
